// File: rtl/mult_share_sched_pkg.sv
// Shared definitions for the multiplier-sharing scheduler: FSM state encoding
// and default sizing. Imported by mult_share_sched and mult_rr_arbiter.
// No logic, no latency, no flow control of its own.
package mult_share_sched_pkg;

   localparam int DEF_NREQ       = 4;
   localparam int DEF_WIDTH      = 16;
   localparam int DEF_WDOG_LIMIT = 65535;
   localparam int WDOG_W         = 16;    // watchdog counter width
   localparam int GID_W          = 3;     // grant index width, covers NREQ up to 8

   // 3-bit state encoding of the scheduler FSM
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LDA  = 3'd1,
      ST_LDB  = 3'd2,
      ST_ITER = 3'd3,
      ST_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/mult_rr_arbiter.sv
// Purpose: combinational round-robin pick of one requester, searching upward
//          from (ptr+1) mod NREQ and wrapping.
// Latency: zero (pure combinational). Backpressure: none, caller samples gnt
//          only when it can accept a grant.
// Ports:
//   req  in  NREQ  request levels
//   ptr  in  3     index of the last served requester
//   gnt  out 3     chosen requester index (0 when vld is low)
//   vld  out 1     at least one request is set
module mult_rr_arbiter
   import mult_share_sched_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
) (
   input  logic [NREQ-1:0]  req,
   input  logic [GID_W-1:0] ptr,
   output logic [GID_W-1:0] gnt,
   output logic             vld
);

   // Widen to 8 so a 3-bit index is always in range whatever NREQ is.
   logic [7:0] req8;
   assign req8 = 8'(req);

   always_comb begin
      logic [GID_W-1:0] idx;
      gnt = '0;
      vld = 1'b0;
      idx = '0;
      // Offset 1 first: the last served requester gets the lowest priority.
      for (int i = 1; i <= NREQ; i++) begin
         idx = GID_W'((int'(ptr) + i) % NREQ);
         if (!vld && req8[idx]) begin
            vld = 1'b1;
            gnt = idx;
         end
      end
   end

endmodule

// File: rtl/mult_share_sched.sv
// Purpose: round-robin scheduler sharing one repeated-addition multiplier
//          datapath (A, B, P regs, eqz flag) among NREQ requesters.
// Latency: req seen in IDLE at cycle t -> ack at t+4+op_b. Backpressure:
//          requests wait (level held) while busy; none lost while held.
// Optional feature: MULT_SCHED_WDOG_EN adds an ITER watchdog (err pulse).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req/op_a/op_b       per-requester request level and packed operands
//   ack/result/err      completion pulse, product, watchdog-abort pulse
//   busy/grant_id       not-idle flag, current/last granted index
//   dp_data + strobes   drive the shared datapath (ld_a ld_b ld_p clr_p dec_b)
//   eqz/dp_prod         datapath B==0 flag and P register
module mult_share_sched
   import mult_share_sched_pkg::*;
#(
   parameter int NREQ       = DEF_NREQ,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*WIDTH-1:0]  op_a,
   input  logic [NREQ*WIDTH-1:0]  op_b,
   output logic [NREQ-1:0]        ack,
   output logic [WIDTH-1:0]       result,
   output logic                   err,
   output logic                   busy,
   output logic [GID_W-1:0]       grant_id,
   output logic [WIDTH-1:0]       dp_data,
   output logic                   ld_a,
   output logic                   ld_b,
   output logic                   ld_p,
   output logic                   clr_p,
   output logic                   dec_b,
   input  logic                   eqz,
   input  logic [WIDTH-1:0]       dp_prod
);

   state_t           state, state_nxt;
   logic [GID_W-1:0] rr_ptr;
   logic [GID_W-1:0] arb_gnt;
   logic             arb_vld;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic             wdog_hit;
   logic             err_q;

   mult_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req (req),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .vld (arb_vld)
   );

   // Operands of the granted requester; req and operands of others are ignored.
   assign sel_a = op_a[int'(grant_id)*WIDTH +: WIDTH];
   assign sel_b = op_b[int'(grant_id)*WIDTH +: WIDTH];

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (arb_vld) state_nxt = ST_LDA;
         ST_LDA:  state_nxt = ST_LDB;
         ST_LDB:  state_nxt = ST_ITER;
         ST_ITER: if (eqz || wdog_hit) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- output decode ----------------
   // Only LDA/LDB drive the bus and only one load strobe is live per state,
   // so ld_a, ld_b and ld_p can never overlap.
   always_comb begin
      dp_data = '0;
      ld_a    = 1'b0;
      ld_b    = 1'b0;
      ld_p    = 1'b0;
      clr_p   = 1'b0;
      dec_b   = 1'b0;
      ack     = '0;
      busy    = (state != ST_IDLE);
      result  = result_q;
      case (state)
         ST_LDA: begin
            dp_data = sel_a;
            ld_a    = 1'b1;
         end
         ST_LDB: begin
            dp_data = sel_b;
            ld_b    = 1'b1;
            clr_p   = 1'b1;
         end
         ST_ITER: begin
            ld_p  = ~eqz;
            dec_b = ~eqz;
         end
         ST_DONE: begin
            ack    = NREQ'(1) << grant_id;
            // P is final in DONE; expose it in the ack cycle, held afterwards.
            result = dp_prod;
         end
         default: ;
      endcase
   end

   // ---------------- grant, pointer, result ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_id <= '0;
         rr_ptr   <= GID_W'(NREQ-1);
         result_q <= '0;
      end else begin
         if (state == ST_IDLE && arb_vld) grant_id <= arb_gnt;
         if (state == ST_DONE) begin
            rr_ptr   <= grant_id;
            result_q <= dp_prod;
         end
      end
   end

`ifdef MULT_SCHED_WDOG_EN
   logic [WDOG_W-1:0] wdog_cnt;

   // wdog_cnt equals the number of ITER cycles already spent, so a hit in
   // the WDOG_LIMIT-th ITER cycle leaves for DONE after exactly WDOG_LIMIT.
   assign wdog_hit = (state == ST_ITER) && !eqz &&
                     (wdog_cnt == WDOG_W'(WDOG_LIMIT-1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wdog_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == ST_LDB)       wdog_cnt <= '0;
         else if (state == ST_ITER) wdog_cnt <= wdog_cnt + 1'b1;
         // Rewritten in every ITER cycle, so it reflects how ITER was left.
         if (state == ST_ITER)      err_q    <= wdog_hit;
      end
   end

   assign err = (state == ST_DONE) && err_q;
`else
   logic unused_wdog;

   assign wdog_hit    = 1'b0;
   assign err_q       = 1'b0;
   assign unused_wdog = ^{err_q, WDOG_LIMIT[0]};
   assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched with a behavioural repeated-addition
// datapath model (A, B, P) closing the loop on eqz / dp_prod.
module tb_mult_share_sched;
   localparam int NREQ  = 4;
   localparam int WIDTH = 16;
   localparam int WDOG  = 8;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] op_a, op_b;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      result;
   logic                  err, busy;
   logic [2:0]            grant_id;
   logic [WIDTH-1:0]      dp_data;
   logic                  ld_a, ld_b, ld_p, clr_p, dec_b;
   logic                  eqz;
   logic [WIDTH-1:0]      dp_prod;

   always #5 clk = ~clk;

   mult_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .WDOG_LIMIT(WDOG)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
      .ack(ack), .result(result), .err(err), .busy(busy), .grant_id(grant_id),
      .dp_data(dp_data), .ld_a(ld_a), .ld_b(ld_b), .ld_p(ld_p), .clr_p(clr_p),
      .dec_b(dec_b), .eqz(eqz), .dp_prod(dp_prod)
   );

   // ---- datapath model ----
   logic [WIDTH-1:0] ra = '0, rb = '0, rp = '0;
   logic             hold_nz;
   assign eqz     = (rb == '0) && !hold_nz;
   assign dp_prod = rp;

   always @(posedge clk) begin
      if (ld_a) ra <= dp_data;
      if (ld_b) rb <= dp_data;
      else if (dec_b) rb <= rb - 1'b1;
      if (clr_p) rp <= '0;
      else if (ld_p) rp <= rp + ra;
   end

   // ---- monitor (free-running counters; the test takes differences) ----
   int ld_p_cnt = 0, clr_cnt = 0, err_cnt = 0, viol = 0;
   int ack_cnt [NREQ];
   initial for (int k = 0; k < NREQ; k++) ack_cnt[k] = 0;

   always @(negedge clk) begin
      if (ld_p) ld_p_cnt++;
      if (clr_p) clr_cnt++;
      if (err) err_cnt++;
      for (int k = 0; k < NREQ; k++) if (ack[k]) ack_cnt[k]++;
      if ((ld_a && ld_b) || (ld_a && ld_p) || (ld_b && ld_p)) viol++;
      if (!ld_a && !ld_b && dp_data != '0) viol++;
      if (!busy && (ld_a || ld_b || ld_p || clr_p || dec_b)) viol++;
   end

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycles until ack is seen, bounded; returns the bound on timeout.
   task automatic wait_ack(output int cyc);
      cyc = 0;
      while (ack == '0 && cyc < 1000) begin
         tick();
         cyc++;
      end
   endtask

   task automatic set_ops(input int i, input int a, input int b);
      op_a[i*WIDTH +: WIDTH] = WIDTH'(a);
      op_b[i*WIDTH +: WIDTH] = WIDTH'(b);
   endtask

   function automatic int ack_sum();
      int s = 0;
      for (int k = 0; k < NREQ; k++) s += ack_cnt[k];
      return s;
   endfunction

   initial begin
      int c, base_ldp, base_clr, base_ack, base_err;
      logic [2:0] exp_g;
      rst_n = 1'b0; req = '0; op_a = '0; op_b = '0; hold_nz = 1'b0;
      tick(); tick();

      // ---- reset state ----
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_grant", 32'(grant_id), 0);
      chk("rst_dpdata", 32'(dp_data), 0);
      chk("rst_strobes", 32'({ld_a, ld_b, ld_p, clr_p, dec_b}), 0);
      rst_n = 1'b1;
      tick();

      // ---- single req[1], 5*3 ----
      set_ops(1, 5, 3);
      base_ldp = ld_p_cnt;
      req = 4'b0010;
      wait_ack(c);
      chk("t1_latency", 32'(c), 7);
      chk("t1_ack", 32'(ack), 32'h2);
      chk("t1_result", 32'(result), 15);
      chk("t1_grant", 32'(grant_id), 1);
      chk("t1_ldp_cycles", 32'(ld_p_cnt - base_ldp), 3);
      req = '0;
      tick();
      chk("t1_hold_result", 32'(result), 15);
      chk("t1_ack_gone", 32'(ack), 0);
      chk("t1_idle", 32'(busy), 0);

      // ---- b=0 on req[3], a=9 ----
      set_ops(3, 9, 0);
      base_ldp = ld_p_cnt; base_clr = clr_cnt;
      req = 4'b1000;
      wait_ack(c);
      chk("t2_latency", 32'(c), 4);
      chk("t2_ack", 32'(ack), 32'h8);
      chk("t2_result", 32'(result), 0);
      chk("t2_no_ldp", 32'(ld_p_cnt - base_ldp), 0);
      chk("t2_clrp", 32'(clr_cnt - base_clr), 1);
      req = '0;
      tick();

      // ---- all four held after reset: rr order 0,1,2,3,0 ----
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) set_ops(i, 3 + i, 2 + i);
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         exp_g = 3'(n % NREQ);
         if (n != 0) tick();
         wait_ack(c);
         chk("t3_latency", 32'(c), 32'(4 + 2 + n % NREQ));
         chk("t3_grant", 32'(grant_id), 32'(exp_g));
         chk("t3_ack_onehot", 32'(ack), 32'(1) << exp_g);
         chk("t3_result", 32'(result), 32'((3 + exp_g) * (2 + exp_g)));
      end
      req = '0;
      tick(); tick();

      // ---- req[2] dropped while in LDB: op completes, no re-grant ----
      set_ops(2, 11, 4);
      base_ack = ack_cnt[2];
      req = 4'b0100;
      tick();                      // LDA
      chk("t4_in_lda", 32'(ld_a), 1);
      tick();                      // LDB
      req = '0;
      wait_ack(c);
      chk("t4_latency", 32'(c + 2), 8);
      chk("t4_ack", 32'(ack), 32'h4);
      chk("t4_result", 32'(result), 44);
      for (int k = 0; k < 6; k++) tick();
      chk("t4_single_ack", 32'(ack_cnt[2] - base_ack), 1);
      chk("t4_no_regrant", 32'(busy), 0);

      // ---- reset during ITER, then re-request 7*200 ----
      set_ops(0, 7, 200);
      base_ack = ack_sum();
      req = 4'b0001;
      for (int k = 0; k < 5; k++) tick();
      chk("t5_in_iter", 32'(dec_b), 1);
      rst_n = 1'b0; req = '0;
      tick();
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_result", 32'(result), 0);
      chk("t5_rst_grant", 32'(grant_id), 0);
      chk("t5_rst_outs", 32'({ack, err, dp_data, ld_a, ld_b, ld_p, clr_p, dec_b}), 0);
      rst_n = 1'b1;
      tick();
      chk("t5_no_ack", 32'(ack_sum() - base_ack), 0);
      req = 4'b0001;
      wait_ack(c);
      chk("t5_latency", 32'(c), 204);
      chk("t5_result", 32'(result), 1400);
      chk("t5_ack", 32'(ack), 32'h1);
      req = '0;
      tick();

`ifdef MULT_SCHED_WDOG_EN
      // ---- watchdog abort: eqz held low ----
      set_ops(1, 2, 3);
      base_err = err_cnt;
      hold_nz = 1'b1;
      req = 4'b0010;
      wait_ack(c);
      chk("t6_latency", 32'(c), 32'(4 + WDOG - 1));
      chk("t6_err_with_ack", 32'({err, ack}), 32'h12);
      chk("t6_partial", 32'(result), 32'(2 * WDOG));
      req = '0; hold_nz = 1'b0;
      tick();
      chk("t6_err_once", 32'(err_cnt - base_err), 1);
`else
      // ---- no watchdog: long op completes, err never seen ----
      set_ops(1, 6, 40);
      base_err = err_cnt;
      req = 4'b0010;
      wait_ack(c);
      chk("t6_latency", 32'(c), 44);
      chk("t6_result", 32'(result), 240);
      req = '0;
      tick();
      chk("t6_no_err", 32'(err_cnt), 0);
      chk("t6_no_err_delta", 32'(err_cnt - base_err), 0);
`endif

      chk("strobe_bus_rules", 32'(viol), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
